// File: rtl/l5_range_decoder_if.sv
// Request/response bundle between the L5 controller and the range decoder.
// The controller drives the request side; the decoder drives the registered enables.
interface l5_range_decoder_if #(
  parameter int unsigned DEC_INBITS  = 5,
  parameter int unsigned DEC_OUTBITS = 32
);
  logic                   req;
  logic [2:0]             sel_range;
  logic [DEC_INBITS-1:0]  lower;
  logic [DEC_INBITS-1:0]  upper;
  logic                   hold;
  logic                   abort;
  logic [DEC_OUTBITS-1:0] decout;
  logic                   dec_valid;
  logic                   dec_last;
  logic                   busy;

  modport master (
    output req, sel_range, lower, upper, hold, abort,
    input  decout, dec_valid, dec_last, busy
  );

  modport slave (
    input  req, sel_range, lower, upper, hold, abort,
    output decout, dec_valid, dec_last, busy
  );
endinterface

// File: rtl/l5_range_decoder.sv
// Registered one-hot / range / all-select decoder for the L5 array enables,
// with a multi-cycle sweep that walks a one-hot select from lower to upper.
module l5_range_decoder #(
  parameter int unsigned DEC_INBITS  = 5,
  parameter int unsigned DEC_OUTBITS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  l5_range_decoder_if.slave    bus
);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  localparam logic [2:0] SelSweep = 3'b101;

  state_e                 state_q, state_d;
  logic [DEC_INBITS-1:0]  idx_q, idx_d;
  logic [DEC_INBITS-1:0]  upper_q, upper_d;
  logic [DEC_OUTBITS-1:0] decout_q, decout_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic [DEC_INBITS-1:0]  idx_next;

  // Indices at or beyond DEC_OUTBITS simply match no bit.
  function automatic logic [DEC_OUTBITS-1:0] onehot(logic [DEC_INBITS-1:0] idx);
    logic [DEC_OUTBITS-1:0] v;
    v = '0;
    for (int i = 0; i < int'(DEC_OUTBITS); i++) v[i] = (int'(idx) == i);
    return v;
  endfunction

  function automatic logic [DEC_OUTBITS-1:0] mask_ge(logic [DEC_INBITS-1:0] lo);
    logic [DEC_OUTBITS-1:0] v;
    v = '0;
    for (int i = 0; i < int'(DEC_OUTBITS); i++) v[i] = (i >= int'(lo));
    return v;
  endfunction

  function automatic logic [DEC_OUTBITS-1:0] mask_le(logic [DEC_INBITS-1:0] hi);
    logic [DEC_OUTBITS-1:0] v;
    v = '0;
    for (int i = 0; i < int'(DEC_OUTBITS); i++) v[i] = (i <= int'(hi));
    return v;
  endfunction

  function automatic logic [DEC_OUTBITS-1:0] decode_static(logic [2:0]            sel,
                                                           logic [DEC_INBITS-1:0] lo,
                                                           logic [DEC_INBITS-1:0] hi);
    logic [DEC_OUTBITS-1:0] v;
    case (sel)
      3'b001:  v = onehot(lo);
      3'b010:  v = onehot(hi);
      // Inverted range keeps the legacy L4 behaviour: lower up to the top bit only.
      3'b011:  v = (lo <= hi) ? (mask_ge(lo) & mask_le(hi)) : mask_ge(lo);
      3'b100:  v = '1;
      3'b110:  v = (lo <= hi) ? (mask_ge(lo) & mask_le(hi)) : (mask_ge(lo) | mask_le(hi));
      default: v = '0;
    endcase
    return v;
  endfunction

  assign idx_next = idx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    upper_d  = upper_q;
    decout_d = decout_q;
    valid_d  = 1'b0;
    last_d   = 1'b0;

    if (bus.abort) begin
      decout_d = '0;
      state_d  = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req) begin
            valid_d = 1'b1;
            if (bus.sel_range == SelSweep) begin
              idx_d    = bus.lower;
              upper_d  = bus.upper;
              decout_d = onehot(bus.lower);
              if (bus.lower == bus.upper) begin
                last_d = 1'b1;
              end else begin
                state_d = StSweep;
              end
            end else begin
              decout_d = decode_static(bus.sel_range, bus.lower, bus.upper);
              last_d   = 1'b1;
            end
          end
        end
        StSweep: begin
          if (!bus.hold) begin
            idx_d    = idx_next;
            decout_d = onehot(idx_next);
            valid_d  = 1'b1;
            if (idx_next == upper_q) begin
              last_d  = 1'b1;
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      upper_q  <= '0;
      decout_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      upper_q  <= upper_d;
      decout_q <= decout_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
    end
  end

  assign bus.decout    = decout_q;
  assign bus.dec_valid = valid_q;
  assign bus.dec_last  = last_q;
  assign bus.busy      = (state_q == StSweep);

endmodule
